// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared types and constants for the OV7670 register-initialisation sequencer:
// the sequencer state encoding, the table marker entries, the default SCCB
// slave address and the built-in OV7670 RGB565/VGA register list.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_SEND,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE
    } cfg_state_t;

    localparam logic [15:0] CFG_END        = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY      = 16'hFFF0;
    localparam logic [7:0]  DEFAULT_CAM_ID = 8'h42;

    // Built-in {register, value} list: soft reset, settle delay, then RGB565 VGA.
    function automatic logic [15:0] default_entry(input int unsigned idx);
        case (idx)
            0:  default_entry = 16'h1280;  // COM7: soft reset
            1:  default_entry = CFG_DELAY; // let the sensor come out of reset
            2:  default_entry = 16'h1204;  // COM7: RGB output, VGA
            3:  default_entry = 16'h1180;  // CLKRC: use external clock directly
            4:  default_entry = 16'h0C00;  // COM3
            5:  default_entry = 16'h3E00;  // COM14: no scaling
            6:  default_entry = 16'h0400;  // COM1
            7:  default_entry = 16'h40D0;  // COM15: RGB565, full range
            8:  default_entry = 16'h3A04;  // TSLB
            9:  default_entry = 16'h1418;  // COM9: AGC ceiling
            10: default_entry = 16'h4FB3;  // colour matrix
            11: default_entry = 16'h50B3;
            12: default_entry = 16'h5100;
            13: default_entry = 16'h523D;
            14: default_entry = 16'h53A7;
            15: default_entry = 16'h54E4;
            16: default_entry = 16'h589E;
            17: default_entry = 16'h3DC0;  // COM13: gamma, UV saturation
            18: default_entry = 16'h1714;  // HSTART
            19: default_entry = 16'h1802;  // HSTOP
            20: default_entry = 16'h3280;  // HREF
            21: default_entry = 16'h1903;  // VSTART
            22: default_entry = 16'h1A7B;  // VSTOP
            23: default_entry = 16'h030A;  // VREF
            24: default_entry = 16'h0F41;  // COM6
            25: default_entry = 16'h1E00;  // MVFP
            26: default_entry = 16'h330B;  // CHLF
            27: default_entry = 16'h3C78;  // COM12
            28: default_entry = 16'h6900;  // GFIX
            29: default_entry = 16'h7400;  // REG74
            30: default_entry = 16'hB084;  // reserved, needed for good colour
            31: default_entry = 16'hB10C;  // ABLC1
            32: default_entry = 16'hB20E;
            33: default_entry = 16'hB380;  // THL_ST
            default: default_entry = CFG_END;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// ov7670_config_rom
// Synchronous-read table of 16-bit {register, value} entries.
// With TABLE_LEN = 0 the built-in OV7670 list is used; otherwise the first
// TABLE_LEN (max 16) entries come from TABLE_INIT (entry i in bits [16*i +: 16])
// and every remaining entry reads as the end-of-table marker.
// Ports:
//   clk_i   in   clock
//   addr_i  in   entry address
//   data_o  out  entry, valid the cycle after addr_i is presented
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int           ROM_DEPTH  = 128,
    parameter int           AW         = 7,
    parameter int           TABLE_LEN  = 0,
    parameter logic [255:0] TABLE_INIT = '0
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    output logic [15:0]   data_o
);

    logic [15:0] mem [ROM_DEPTH];

    generate
        for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_entry
            if (TABLE_LEN == 0) begin : g_default
                assign mem[gi] = default_entry(gi);
            end else if (gi < TABLE_LEN && gi < 16) begin : g_user
                assign mem[gi] = TABLE_INIT[16*gi +: 16];
            end else begin : g_pad
                assign mem[gi] = CFG_END;
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        data_o <= mem[addr_i];
    end

endmodule

// File: rtl/ov7670_config.sv
// ov7670_config
// Walks the register table and hands each {register, value} entry to the SCCB
// interface via the send/taken handshake. FFFF ends the table; FFF0 is a delay
// marker. Optional feature macro: OV7670_CFG_DELAY_EN -- when defined, FFF0
// waits DELAY_MS milliseconds; when undefined, FFF0 is skipped and no delay
// counter is built.
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   single-cycle request to run the table from address 0
//   taken_i  in   SCCB idle/finished flag
//   send_o   out  transfer request to the SCCB interface
//   id_o     out  SCCB slave address (CAM_ID)
//   regi_o   out  register address of the current entry
//   value_o  out  register value of the current entry
//   busy_o   out  sequence running
//   done_o   out  table completed, held until next start or reset
module ov7670_config
    import ov7670_pkg::*;
#(
    parameter int           CLK_FREQ   = 25_000_000,
    parameter logic [7:0]   CAM_ID     = DEFAULT_CAM_ID,
    parameter int           ROM_DEPTH  = 128,
    parameter int           DELAY_MS   = 10,
    parameter int           AUTO_START = 1,
    parameter int           TABLE_LEN  = 0,
    parameter logic [255:0] TABLE_INIT = '0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       taken_i,
    output logic       send_o,
    output logic [7:0] id_o,
    output logic [7:0] regi_o,
    output logic [7:0] value_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int            AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

    cfg_state_t    state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          send_reg, send_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [7:0]    regi_reg, regi_next;
    logic [7:0]    value_reg, value_next;
    logic          auto_reg, auto_next;   // auto-start still owed since reset
    logic          launch;
    logic          advance;
    logic [15:0]   rom_data;

`ifdef OV7670_CFG_DELAY_EN
    localparam longint      DELAY_TOTAL = longint'(DELAY_MS) * longint'(CLK_FREQ) / 1000;
    // Counting down to 0 inclusive, so load one less for an exact DELAY_TOTAL.
    localparam logic [31:0] DELAY_LOAD  = (DELAY_TOTAL > 0) ? 32'(DELAY_TOTAL - 1) : 32'd0;
    logic [31:0] delay_reg, delay_next;
`endif

    ov7670_config_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .AW        (AW),
        .TABLE_LEN (TABLE_LEN),
        .TABLE_INIT(TABLE_INIT)
    ) u_rom (
        .clk_i (clk_i),
        .addr_i(addr_reg),
        .data_o(rom_data)
    );

    // start_i is only honoured outside a run, so pulses while busy are dropped.
    assign launch = ((state_reg == ST_IDLE) && (start_i || ((AUTO_START != 0) && auto_reg)))
                 || ((state_reg == ST_DONE) && start_i);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        send_next  = send_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        regi_next  = regi_reg;
        value_next = value_reg;
        auto_next  = auto_reg;
        advance    = 1'b0;
`ifdef OV7670_CFG_DELAY_EN
        delay_next = delay_reg;
`endif
        case (state_reg)
            ST_FETCH: state_next = ST_CHECK;
            ST_CHECK: begin
                if (rom_data == CFG_END) begin
                    state_next = ST_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else if (rom_data == CFG_DELAY) begin
`ifdef OV7670_CFG_DELAY_EN
                    delay_next = DELAY_LOAD;
                    state_next = ST_DELAY;
`else
                    advance    = 1'b1;
`endif
                end else begin
                    regi_next  = rom_data[15:8];
                    value_next = rom_data[7:0];
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (taken_i) begin
                    send_next  = 1'b1;
                    state_next = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (!taken_i) begin
                    send_next  = 1'b0;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: advance = taken_i;
`ifdef OV7670_CFG_DELAY_EN
            ST_DELAY: begin
                if (delay_reg == 32'd0) begin
                    advance = 1'b1;
                end else begin
                    delay_next = delay_reg - 32'd1;
                end
            end
`endif
            ST_IDLE, ST_DONE: ;
            default: state_next = ST_IDLE;
        endcase

        if (advance) begin
            if (addr_reg == LAST_ADDR) begin
                state_next = ST_DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end else begin
                addr_next  = addr_reg + AW'(1);
                state_next = ST_FETCH;
            end
        end

        if (launch) begin
            addr_next  = '0;
            done_next  = 1'b0;
            busy_next  = 1'b1;
            auto_next  = 1'b0;
            state_next = ST_FETCH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            send_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            regi_reg  <= 8'h00;
            value_reg <= 8'h00;
            auto_reg  <= 1'b1;
`ifdef OV7670_CFG_DELAY_EN
            delay_reg <= 32'd0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            send_reg  <= send_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            regi_reg  <= regi_next;
            value_reg <= value_next;
            auto_reg  <= auto_next;
`ifdef OV7670_CFG_DELAY_EN
            delay_reg <= delay_next;
`endif
        end
    end

    assign send_o  = send_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;
    assign regi_o  = regi_reg;
    assign value_o = value_reg;
    assign id_o    = CAM_ID;

endmodule

// File: tb/tb_ov7670_config.sv
// Bench for ov7670_config. Three instances:
//   a: table {1280, FFF0, 1104, FFFF}, auto start, 1000-cycle delay
//   b: table {FFFF}, no auto start
//   c: depth 4, table {0A01, 0B02, 0C03, 0D04} with no end marker, auto start
// A shared SCCB model drops taken 10 cycles after send and raises it 50 later.
module tb_ov7670_config;

    localparam int DELAY_N = 1000;  // 10 ms at 100 kHz
`ifdef OV7670_CFG_DELAY_EN
    localparam int EXP_GAP = 6 + DELAY_N;
`else
    localparam int EXP_GAP = 6;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b, rst_c, start_a, start_b, start_c;
    logic send_a, send_b, send_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [7:0] id_a, id_b, id_c, regi_a, regi_b, regi_c, value_a, value_b, value_c;

    logic [2:0] taken_v = 3'b111;
    logic [2:0] send_v, busy_v, done_v;
    logic [15:0] entry_v [3];
    assign send_v = {send_c, send_b, send_a};
    assign busy_v = {busy_c, busy_b, busy_a};
    assign done_v = {done_c, done_b, done_a};
    assign entry_v[0] = {regi_a, value_a};
    assign entry_v[1] = {regi_b, value_b};
    assign entry_v[2] = {regi_c, value_c};

    ov7670_config #(.CLK_FREQ(100_000), .ROM_DEPTH(8), .DELAY_MS(10), .AUTO_START(1), .TABLE_LEN(4),
        .TABLE_INIT({192'h0, 16'hFFFF, 16'h1104, 16'hFFF0, 16'h1280}))
    dut_a (.clk_i(clk), .rst_ni(rst_a), .start_i(start_a), .taken_i(taken_v[0]), .send_o(send_a),
        .id_o(id_a), .regi_o(regi_a), .value_o(value_a), .busy_o(busy_a), .done_o(done_a));

    ov7670_config #(.CLK_FREQ(100_000), .ROM_DEPTH(8), .DELAY_MS(10), .AUTO_START(0), .TABLE_LEN(1),
        .TABLE_INIT({240'h0, 16'hFFFF}))
    dut_b (.clk_i(clk), .rst_ni(rst_b), .start_i(start_b), .taken_i(taken_v[1]), .send_o(send_b),
        .id_o(id_b), .regi_o(regi_b), .value_o(value_b), .busy_o(busy_b), .done_o(done_b));

    ov7670_config #(.CLK_FREQ(100_000), .ROM_DEPTH(4), .DELAY_MS(10), .AUTO_START(1), .TABLE_LEN(4),
        .TABLE_INIT({192'h0, 16'h0D04, 16'h0C03, 16'h0B02, 16'h0A01}))
    dut_c (.clk_i(clk), .rst_ni(rst_c), .start_i(start_c), .taken_i(taken_v[2]), .send_o(send_c),
        .id_o(id_c), .regi_o(regi_c), .value_o(value_c), .busy_o(busy_c), .done_o(done_c));

    // SCCB model and transfer log
    int          mcnt [3]     = '{0, 0, 0};
    logic [2:0]  send_prev    = 3'b000;
    int          xfer_cnt [3] = '{0, 0, 0};
    int          fend_cnt [3] = '{0, 0, 0};
    logic [15:0] xfer_data [3][64];
    int          xfer_cyc [3][64];
    int          fend_cyc [3][64];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            send_prev[i] <= send_v[i];
            if (send_v[i] && !send_prev[i]) begin
                if (xfer_cnt[i] < 64) begin
                    xfer_data[i][xfer_cnt[i]] <= entry_v[i];
                    xfer_cyc[i][xfer_cnt[i]]  <= cyc;
                end
                xfer_cnt[i] <= xfer_cnt[i] + 1;
            end
            if (mcnt[i] == 0) begin
                if (send_v[i] && taken_v[i]) mcnt[i] <= 1;
            end else if (mcnt[i] == 10) begin
                taken_v[i] <= 1'b0;
                mcnt[i]    <= 11;
            end else if (mcnt[i] == 60) begin
                taken_v[i] <= 1'b1;
                mcnt[i]    <= 0;
                if (fend_cnt[i] < 64) fend_cyc[i][fend_cnt[i]] <= cyc;
                fend_cnt[i] <= fend_cnt[i] + 1;
            end else begin
                mcnt[i] <= mcnt[i] + 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic wait_done(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_send(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (send_v[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (send_b !== 1'b0) begin fails++; $display("FAIL reset_send got=%b exp=0", send_b); end
        tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_b); end
        tests++; if (done_b !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done_b); end
        tests++; if ({regi_b, value_b} !== 16'h0000) begin fails++; $display("FAIL reset_regval got=%h exp=0000", {regi_b, value_b}); end
        tests++; if (id_b !== 8'h42) begin fails++; $display("FAIL reset_id got=%h exp=42", id_b); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL no_autostart_busy got=%b exp=0", busy_b); end
        $display("[TB] reset: outputs checked in reset and after release without auto start");
    endtask

    task automatic test_empty_table;
        int x0;
        bit ok;
        x0 = xfer_cnt[1];
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL empty_busy got=%b exp=1", busy_b); end
        wait_done(1, 20, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL empty_done_timeout got=%b exp=1", ok); end
        tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL empty_busy_end got=%b exp=0", busy_b); end
        repeat (5) @(negedge clk);
        tests++; if (xfer_cnt[1] - x0 !== 0) begin fails++; $display("FAIL empty_sends got=%0d exp=0", xfer_cnt[1] - x0); end
        $display("[TB] empty table: done without transfer");
    endtask

    task automatic test_main;
        int x0, f0;
        bit ok;
        x0 = xfer_cnt[0];
        f0 = fend_cnt[0];
        rst_a = 1'b1;
        wait_done(0, 5000, ok);
        repeat (2) @(negedge clk);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL main_done_timeout got=%b exp=1", ok); end
        tests++; if (xfer_cnt[0] - x0 !== 2) begin fails++; $display("FAIL main_count got=%0d exp=2", xfer_cnt[0] - x0); end
        tests++; if (xfer_data[0][x0] !== 16'h1280) begin fails++; $display("FAIL main_xfer0 got=%h exp=1280", xfer_data[0][x0]); end
        tests++; if (xfer_data[0][x0+1] !== 16'h1104) begin fails++; $display("FAIL main_xfer1 got=%h exp=1104", xfer_data[0][x0+1]); end
        tests++; if (xfer_cyc[0][x0+1] - fend_cyc[0][f0] !== EXP_GAP) begin fails++;
            $display("FAIL main_gap got=%0d exp=%0d", xfer_cyc[0][x0+1] - fend_cyc[0][f0], EXP_GAP); end
        tests++; if ({busy_a, done_a} !== 2'b01) begin fails++; $display("FAIL main_end_flags got=%b exp=01", {busy_a, done_a}); end
        $display("[TB] main: 2 transfers, gap %0d cycles", xfer_cyc[0][x0+1] - fend_cyc[0][f0]);
    endtask

    task automatic test_start_while_busy;
        int x0;
        bit ok;
        x0 = xfer_cnt[0];
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        tests++; if ({busy_a, done_a} !== 2'b10) begin fails++; $display("FAIL rerun_flags got=%b exp=10", {busy_a, done_a}); end
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 5000, ok);
        repeat (2) @(negedge clk);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rerun_done_timeout got=%b exp=1", ok); end
        tests++; if (xfer_cnt[0] - x0 !== 2) begin fails++; $display("FAIL rerun_count got=%0d exp=2", xfer_cnt[0] - x0); end
        tests++; if (xfer_data[0][x0] !== 16'h1280) begin fails++; $display("FAIL rerun_xfer0 got=%h exp=1280", xfer_data[0][x0]); end
        tests++; if (xfer_data[0][x0+1] !== 16'h1104) begin fails++; $display("FAIL rerun_xfer1 got=%h exp=1104", xfer_data[0][x0+1]); end
        $display("[TB] start while busy ignored, rerun after done from address 0");
    endtask

    task automatic test_reset_mid;
        int x0;
        bit ok;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_send(0, 200, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL midrst_send_timeout got=%b exp=1", ok); end
        rst_a = 1'b0;
        #1;
        tests++; if (send_a !== 1'b0) begin fails++; $display("FAIL midrst_send got=%b exp=0", send_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
        repeat (80) @(negedge clk);
        x0 = xfer_cnt[0];
        rst_a = 1'b1;
        wait_done(0, 5000, ok);
        repeat (2) @(negedge clk);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL midrst_done_timeout got=%b exp=1", ok); end
        tests++; if (xfer_cnt[0] - x0 !== 2) begin fails++; $display("FAIL midrst_count got=%0d exp=2", xfer_cnt[0] - x0); end
        tests++; if (xfer_data[0][x0] !== 16'h1280) begin fails++; $display("FAIL midrst_xfer0 got=%h exp=1280", xfer_data[0][x0]); end
        $display("[TB] reset during accept: outputs cleared, sequence restarted");
    endtask

    task automatic test_no_wrap;
        int x0;
        bit ok;
        logic [15:0] exp_tbl [4] = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04};
        x0 = xfer_cnt[2];
        rst_c = 1'b1;
        wait_done(2, 2000, ok);
        repeat (2) @(negedge clk);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL nowrap_done_timeout got=%b exp=1", ok); end
        tests++; if (xfer_cnt[2] - x0 !== 4) begin fails++; $display("FAIL nowrap_count got=%0d exp=4", xfer_cnt[2] - x0); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (xfer_data[2][x0+k] !== exp_tbl[k]) begin fails++;
                $display("FAIL nowrap_xfer%0d got=%h exp=%h", k, xfer_data[2][x0+k], exp_tbl[k]); end
        end
        repeat (100) @(negedge clk);
        tests++; if (xfer_cnt[2] - x0 !== 4) begin fails++; $display("FAIL nowrap_after got=%0d exp=4", xfer_cnt[2] - x0); end
        tests++; if ({busy_c, done_c} !== 2'b01) begin fails++; $display("FAIL nowrap_flags got=%b exp=01", {busy_c, done_c}); end
        $display("[TB] depth 4 without end marker: 4 transfers, no wrap");
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_empty_table;
        test_main;
        test_start_while_busy;
        test_reset_mid;
        test_no_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
